bcd_to_binary_seq: RTL and testbench
====================================

Name: bcd_to_binary_seq

Overview:
- Sequential reverse double-dabble converter: takes a packed BCD number and returns its binary value. This is the inverse of the binary-to-BCD path that feeds the seven-segment drivers.
- Sits between decimal-entry logic (switch or key digit entry) and the multiplier datapath, so operands can be entered in decimal.
- Valid/ready handshake on both sides; one shift-and-correct step per clock.

Parameters:
- DIGITS, 4, number of BCD digits on bcd_in.
- BIN_W, 14, width of bin_out; must satisfy 2^BIN_W > 10^DIGITS - 1.

Ports:
- clk  input  1  system clock (50 MHz on board).
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  bcd_in holds a request.
- in_ready  output  1  block can accept a request (high only in IDLE).
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- out_valid  output  1  bin_out and err_digit are valid.
- out_ready  input  1  consumer accepts the result.
- bin_out  output  BIN_W  converted binary value.
- err_digit  output  1  at least one input nibble was greater than 9.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state IDLE, in_ready=1, out_valid=0, bin_out=0, err_digit=0.
  - Shift register and counter cleared.
  - Reset during CONV or DONE aborts silently; no result is produced.
- Internal shift register S, width 8*DIGITS. Upper half holds BCD digits, lower half builds the binary result. Step counter cnt, range 0..4*DIGITS.
- States:
  - IDLE: in_ready=1.
    - On in_valid && in_ready, if any nibble of bcd_in is greater than 9: go to DONE with err_digit=1, bin_out=0. This takes 1 edge.
    - Otherwise: load S={bcd_in, 0}, cnt=0, err_digit=0, go to CONV.
  - CONV: in_ready=0, out_valid=0. Each edge performs one step:
    - S = S >> 1.
    - Then every upper-half nibble that is 8 or more has 3 subtracted.
    - cnt increments.
    - On the edge where cnt reaches 4*DIGITS: bin_out = lower half of S truncated to BIN_W, go to DONE.
  - DONE: out_valid=1. bin_out and err_digit are held stable until out_valid && out_ready; that edge returns to IDLE.
- Latency, no macro: out_valid rises 4*DIGITS+1 edges after the accept edge (17 for DIGITS=4).
  - 1 accept edge, then 16 CONV edges.
  - Error path: out_valid rises 1 edge after accept.
- Throughput: at least one idle cycle between results, since in_ready is low in CONV and DONE.
- Back-pressure: out_ready held low keeps DONE indefinitely with outputs stable.
- in_valid outside IDLE is ignored. bcd_in is sampled only on the accept edge; later changes have no effect.
- Maximum input 9999 gives 0x270F, which fits BIN_W=14 with no overflow.
- The corrected value is the next-state value; no combinational path runs from bcd_in to bin_out.

Optional Feature:
- Macro: B2B_EARLY_EXIT_EN.
- Defined:
  - In CONV, if the upper half of S is zero at the start of a step, that edge does not shift.
  - Instead: bin_out = (lower half) >> (4*DIGITS - cnt), go to DONE.
  - Latency becomes data-dependent:
    - input 0000: out_valid 2 edges after accept;
    - input 0001: 3 edges after accept.
  - Results are identical to the non-macro build.
- Undefined: fixed latency of 4*DIGITS+1 edges.

Test Plan:
- Reset mid-conversion: accept 5678, assert rst_n low on CONV step 5 → in_ready=1, out_valid=0, bin_out=0. Next request 0042 → bin_out=42.
- Nominal: bcd_in=0x1234 with in_valid for 1 cycle, out_ready=1 → bin_out=0x04D2 (1234), err_digit=0, out_valid exactly 17 edges after accept (non-macro build).
- Boundaries: inputs 0x0000 → 0; 0x0009 → 9; 0x0010 → 10; 0x9999 → 0x270F. Each has err_digit=0.
- Invalid digit: bcd_in=0x12A4 → out_valid 1 edge after accept, err_digit=1, bin_out=0.
- Handshake: out_ready held low for 20 cycles after a 0x0500 conversion → out_valid stays 1, bin_out=500 stable, in_ready=0, in_valid pulses with 0x0777 ignored. Then out_ready=1 → IDLE next edge.
- Early exit (B2B_EARLY_EXIT_EN defined): 0x0000 → out_valid at edge 2; 0x0001 → edge 3, value 1; 0x1000 → value 1000. All values match the non-macro build.

Source files
------------

// File: rtl/bcd_to_binary_seq.sv
// Sequential reverse double-dabble: packed BCD in, binary out, one shift/correct step per clock.
// Optional B2B_EARLY_EXIT_EN finishes as soon as the BCD half of the shift register is empty.
module bcd_to_binary_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err_digit
);
    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // CONV  | one shift-right plus nibble correction per edge
    // DONE  | result held until out_ready

    localparam int HALF = 4 * DIGITS;
    localparam int SW   = 8 * DIGITS;
    localparam int CW   = $clog2(HALF + 1);
    localparam logic [CW-1:0] STEPS = CW'(HALF);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state;
    logic [SW-1:0]   s;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   s_step;
    logic [CW-1:0]   cnt_nxt;
    logic            bad_digit;
    logic            early_hit;
    logic [HALF-1:0] early_val;

    function automatic logic [SW-1:0] correct(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[HALF+4*i +: 4] >= 4'd8)
                r[HALF+4*i +: 4] = r[HALF+4*i +: 4] - 4'd3;
        end
        return r;
    endfunction

    function automatic logic any_bad(input logic [HALF-1:0] v);
        logic b;
        b = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9)
                b = 1'b1;
        end
        return b;
    endfunction

    // Zero-extend or truncate the binary half to the output width.
    function automatic logic [BIN_W-1:0] to_bin(input logic [HALF-1:0] v);
        logic [HALF+BIN_W-1:0] ext;
        ext = {{BIN_W{1'b0}}, v};
        return ext[BIN_W-1:0];
    endfunction

    assign s_step    = correct(s >> 1);
    assign cnt_nxt   = cnt + CW'(1);
    assign bad_digit = any_bad(bcd_in);
    assign early_val = s[HALF-1:0] >> (STEPS - cnt);

`ifdef B2B_EARLY_EXIT_EN
    assign early_hit = (s[SW-1:HALF] == '0);
`else
    assign early_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            bin_out   <= '0;
            err_digit <= 1'b0;
            s         <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (bad_digit) begin
                            err_digit <= 1'b1;
                            bin_out   <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            s         <= {bcd_in, {HALF{1'b0}}};
                            cnt       <= '0;
                            err_digit <= 1'b0;
                            state     <= CONV;
                        end
                    end
                end
                CONV: begin
                    if (early_hit) begin
                        bin_out   <= to_bin(early_val);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        s   <= s_step;
                        cnt <= cnt_nxt;
                        if (cnt_nxt == STEPS) begin
                            bin_out   <= to_bin(s_step[HALF-1:0]);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed bench for bcd_to_binary_seq: vector table plus reset, back-pressure and early-exit sequences.
module tb_bcd_to_binary_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] bin_out;
    logic        err_digit;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef B2B_EARLY_EXIT_EN
    localparam int NLAT = -1;
`else
    localparam int NLAT = 17;
`endif

    typedef struct {
        logic [15:0] bcd;
        logic [13:0] bin;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    bcd_to_binary_seq #(.DIGITS(4), .BIN_W(14)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .bin_out(bin_out), .err_digit(err_digit)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Accept one request at the next edge, then count edges (accept edge = 1) until out_valid.
    task automatic convert(input logic [15:0] bcd, output int edges);
        bcd_in   = bcd;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bcd_in   = 16'hFFFF;
        edges    = 1;
        while (!out_valid && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    initial begin
        int e;
        vecs[0]  = '{16'h1234, 14'd1234, 1'b0, NLAT};
        vecs[1]  = '{16'h0000, 14'd0,    1'b0, NLAT};
        vecs[2]  = '{16'h0009, 14'd9,    1'b0, NLAT};
        vecs[3]  = '{16'h0010, 14'd10,   1'b0, NLAT};
        vecs[4]  = '{16'h9999, 14'h270F, 1'b0, NLAT};
        vecs[5]  = '{16'h12A4, 14'd0,    1'b1, 1};
        vecs[6]  = '{16'h000F, 14'd0,    1'b1, 1};
        vecs[7]  = '{16'hA000, 14'd0,    1'b1, 1};
        vecs[8]  = '{16'h1000, 14'd1000, 1'b0, NLAT};
        vecs[9]  = '{16'h0042, 14'd42,   1'b0, NLAT};
        vecs[10] = '{16'h0807, 14'd807,  1'b0, NLAT};
        vecs[11] = '{16'h5678, 14'd5678, 1'b0, NLAT};

        rst_n = 1'b0; in_valid = 1'b0; bcd_in = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bin_out", bin_out, 0);
        chk("rst_err", err_digit, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            convert(vecs[i].bcd, e);
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_bin", i), bin_out, vecs[i].bin);
            chk($sformatf("v%0d_err", i), err_digit, vecs[i].err);
            if (vecs[i].lat >= 0)
                chk($sformatf("v%0d_latency", i), e, vecs[i].lat);
            @(posedge clk); #1;
            chk($sformatf("v%0d_back_idle", i), in_ready, 1);
            chk($sformatf("v%0d_valid_drop", i), out_valid, 0);
        end

        // Reset in the middle of a conversion.
        bcd_in = 16'h5678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_bin", bin_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        convert(16'h0042, e);
        chk("postrst_bin", bin_out, 42);
        if (NLAT >= 0) chk("postrst_latency", e, NLAT);
        @(posedge clk); #1;

        // Back-pressure: hold result, ignore new requests.
        out_ready = 1'b0;
        convert(16'h0500, e);
        chk("bp_valid_first", out_valid, 1);
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            bcd_in   = 16'h0777;
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_bin", bin_out, 500);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("bp_no_ghost", out_valid, 0);

        // Latency corners for small values.
        convert(16'h0000, e);
`ifdef B2B_EARLY_EXIT_EN
        chk("ee_zero_latency", e, 2);
`else
        chk("zero_latency", e, 17);
`endif
        chk("zero_bin", bin_out, 0);
        @(posedge clk); #1;
        convert(16'h0001, e);
`ifdef B2B_EARLY_EXIT_EN
        chk("ee_one_latency", e, 3);
`else
        chk("one_latency", e, 17);
`endif
        chk("one_bin", bin_out, 1);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
